// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
//
// Shared definitions for the ID/EX pipeline register of the lab CPU and its
// operand-forwarding multiplexer.
//
// Contents:
//   REGFILE_ADDRESS_WIDTH  register index width (register 0 reads as zero)
//   DMEM_ADDRESS_WIDTH     width of operand A / data-memory address
//   DATA_WIDTH             width of operand B and of all forwarded results
//   fwd_sel_e              which source an operand was taken from
//   ctrl_t                 decoded control bundle (reg_write, mem_read, mem_write)
//   stage_action_e         what the stage register does on the next edge
//   is_bypass()            true when a select code refers to a pipeline bypass
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int REGFILE_ADDRESS_WIDTH = 3;
    localparam int DMEM_ADDRESS_WIDTH    = 8;
    localparam int DATA_WIDTH            = 64;

    // Saturation ceiling for the optional hazard counters.
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    // Operand source select.
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,  // register-file read data
        FWD_EXM  = 2'd1,  // EX/MEM result
        FWD_MWB  = 2'd2,  // MEM/WB result
        FWD_ZERO = 2'd3   // register 0, hard-wired zero
    } fwd_sel_e;

    // Control bundle; field order is fixed and shared by every stage.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Resolved per-cycle action of the stage register (reset is handled
    // directly in the register process and takes precedence over all of these).
    typedef enum logic [1:0] {
        ACT_CAPTURE  = 2'd0,  // take the incoming instruction (valid or bubble)
        ACT_LOAD_USE = 2'd1,  // insert a bubble, hold IF/ID
        ACT_HOLD     = 2'd2,  // freeze everything, hold IF/ID
        ACT_FLUSH    = 2'd3   // kill the incoming instruction
    } stage_action_e;

    function automatic logic is_bypass(input fwd_sel_e sel);
        return (sel == FWD_EXM) || (sel == FWD_MWB);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// id_ex_stage_fwd_mux
//
// Purely combinational operand selector for one register-file source.
// Priority, highest first:
//   1. source index 0             -> zero
//   2. EX/MEM writeback to index  -> exm_data
//   3. MEM/WB writeback to index  -> mwb_data
//   4. otherwise                  -> rf_data
//
// Ports:
//   src_idx        in   register index being read
//   rf_data        in   register-file read data for that index
//   exm_reg_write  in   EX/MEM writeback pending
//   exm_waddr      in   EX/MEM destination index
//   exm_data       in   EX/MEM result
//   mwb_reg_write  in   MEM/WB writeback pending
//   mwb_waddr      in   MEM/WB destination index
//   mwb_data       in   MEM/WB result
//   operand        out  selected operand value
//   sel_o          out  select code (fwd_sel_e) for the chosen source
// -----------------------------------------------------------------------------
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] src_idx,
    input  logic [DATA_WIDTH-1:0]            rf_data,
    input  logic                             exm_reg_write,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] exm_waddr,
    input  logic [DATA_WIDTH-1:0]            exm_data,
    input  logic                             mwb_reg_write,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] mwb_waddr,
    input  logic [DATA_WIDTH-1:0]            mwb_data,
    output logic [DATA_WIDTH-1:0]            operand,
    output logic [1:0]                       sel_o
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_NONE;
        if (src_idx == '0) begin
            sel = FWD_ZERO;
        end else if (exm_reg_write && (exm_waddr == src_idx)) begin
            // The younger producer wins when both bypasses hit the same index.
            sel = FWD_EXM;
        end else if (mwb_reg_write && (mwb_waddr == src_idx)) begin
            sel = FWD_MWB;
        end
    end

    always_comb begin
        operand = rf_data;
        case (sel)
            FWD_ZERO: operand = '0;
            FWD_EXM:  operand = exm_data;
            FWD_MWB:  operand = mwb_data;
            default:  operand = rf_data;
        endcase
    end

    assign sel_o = sel;

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the lab CPU. Takes the two register-file read
// ports, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, detects
// load-use hazards (one-cycle IF/ID stall plus a bubble) and honours a
// downstream hold and flush.
//
// Next-edge priority: reset > flush_i > hold_i > load-use > normal capture.
//
// Ports:
//   clock, reset                       rising-edge clock, synchronous active-high reset
//   in_valid                           decoded instruction present
//   in_r1addr / in_r1data              source 1 index / regfile data (operand A, address)
//   in_r2addr / in_r2data              source 2 index / regfile data (operand B, store data)
//   in_waddr                           destination index
//   in_reg_write/in_mem_read/in_mem_write  decoded controls
//   exm_reg_write/exm_waddr/exm_data   EX/MEM bypass
//   mwb_reg_write/mwb_waddr/mwb_data   MEM/WB bypass
//   hold_i                             downstream stall: freeze the stage
//   flush_i                            kill the instruction entering the stage
//   stall_o                            to IF/ID: do not advance
//   out_valid, out_addr, out_sdata, out_waddr   registered instruction
//   out_reg_write/out_mem_read/out_mem_write    registered controls, gated by out_valid
//
// Build option ID_EX_HAZARD_STATS_EN adds two saturating 32-bit counters:
//   stall_count  cycles in which a load-use bubble was inserted
//   fwd_count    captured valid instructions that used any bypass
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] in_r1addr,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] in_r2addr,
    input  logic [DMEM_ADDRESS_WIDTH-1:0]    in_r1data,
    input  logic [DATA_WIDTH-1:0]            in_r2data,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] in_waddr,
    input  logic                             in_reg_write,
    input  logic                             in_mem_read,
    input  logic                             in_mem_write,
    input  logic                             exm_reg_write,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] exm_waddr,
    input  logic [DATA_WIDTH-1:0]            exm_data,
    input  logic                             mwb_reg_write,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] mwb_waddr,
    input  logic [DATA_WIDTH-1:0]            mwb_data,
    input  logic                             hold_i,
    input  logic                             flush_i,
    output logic                             stall_o,
    output logic                             out_valid,
    output logic [DMEM_ADDRESS_WIDTH-1:0]    out_addr,
    output logic [DATA_WIDTH-1:0]            out_sdata,
    output logic [REGFILE_ADDRESS_WIDTH-1:0] out_waddr,
    output logic                             out_reg_write,
    output logic                             out_mem_read,
    output logic                             out_mem_write
`ifdef ID_EX_HAZARD_STATS_EN
    ,
    output logic [31:0]                      stall_count,
    output logic [31:0]                      fwd_count
`endif
);

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] op_a_full;
    logic [DATA_WIDTH-1:0] op_b;
    logic [1:0]            sel_a_raw;
    logic [1:0]            sel_b_raw;
    fwd_sel_e              sel_a;
    fwd_sel_e              sel_b;

    // Operand A is narrow: zero-extend the regfile data into the shared mux
    // and keep only the low address bits of whatever it selects.
    id_ex_stage_fwd_mux u_fwd_a (
        .src_idx       (in_r1addr),
        .rf_data       ({{(DATA_WIDTH-DMEM_ADDRESS_WIDTH){1'b0}}, in_r1data}),
        .exm_reg_write (exm_reg_write),
        .exm_waddr     (exm_waddr),
        .exm_data      (exm_data),
        .mwb_reg_write (mwb_reg_write),
        .mwb_waddr     (mwb_waddr),
        .mwb_data      (mwb_data),
        .operand       (op_a_full),
        .sel_o         (sel_a_raw)
    );

    id_ex_stage_fwd_mux u_fwd_b (
        .src_idx       (in_r2addr),
        .rf_data       (in_r2data),
        .exm_reg_write (exm_reg_write),
        .exm_waddr     (exm_waddr),
        .exm_data      (exm_data),
        .mwb_reg_write (mwb_reg_write),
        .mwb_waddr     (mwb_waddr),
        .mwb_data      (mwb_data),
        .operand       (op_b),
        .sel_o         (sel_b_raw)
    );

    assign sel_a = fwd_sel_e'(sel_a_raw);
    assign sel_b = fwd_sel_e'(sel_b_raw);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                             valid_q, valid_d;
    logic [DMEM_ADDRESS_WIDTH-1:0]    addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]            sdata_q, sdata_d;
    logic [REGFILE_ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
    ctrl_t                            ctrl_q,  ctrl_d;
    ctrl_t                            in_ctrl;

    assign in_ctrl = '{reg_write: in_reg_write,
                       mem_read:  in_mem_read,
                       mem_write: in_mem_write};

    // ------------------------------------------------------------------
    // Hazard detection and action decode
    // ------------------------------------------------------------------
    logic          load_use;
    stage_action_e action;

    // A load sitting in this stage whose destination is read by the incoming
    // instruction. Its data only exists after MEM, so the consumer waits one
    // cycle and then picks the value up from the MEM/WB bypass.
    always_comb begin
        load_use = in_valid && valid_q && ctrl_q.mem_read &&
                   (waddr_q != '0) &&
                   ((waddr_q == in_r1addr) || (waddr_q == in_r2addr));
    end

    always_comb begin
        action = ACT_CAPTURE;
        if (flush_i) begin
            action = ACT_FLUSH;
        end else if (hold_i) begin
            // A pending load-use bubble waits until the hold is released.
            action = ACT_HOLD;
        end else if (load_use) begin
            action = ACT_LOAD_USE;
        end
    end

    // Reset overrides the stall combinationally so IF/ID is released in the
    // same cycle reset is asserted.
    always_comb begin
        stall_o = 1'b0;
        if (!reset) begin
            stall_o = (action == ACT_HOLD) || (action == ACT_LOAD_USE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        waddr_d = waddr_q;
        ctrl_d  = ctrl_q;
        case (action)
            ACT_FLUSH: begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_NONE;
            end
            ACT_LOAD_USE: begin
                // Payload is kept; the bubble is made by valid alone and the
                // outputs are gated.
                valid_d = 1'b0;
            end
            ACT_HOLD: begin
                valid_d = valid_q;
            end
            default: begin
                // in_valid = 0 captures a bubble the same way.
                valid_d = in_valid;
                addr_d  = op_a_full[DMEM_ADDRESS_WIDTH-1:0];
                sdata_d = op_b;
                waddr_d = in_waddr;
                ctrl_d  = in_ctrl;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            sdata_q <= '0;
            waddr_q <= '0;
            ctrl_q  <= CTRL_NONE;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            waddr_q <= waddr_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid     = valid_q;
    assign out_addr      = addr_q;
    assign out_sdata     = sdata_q;
    assign out_waddr     = waddr_q;
    assign out_reg_write = valid_q & ctrl_q.reg_write;
    assign out_mem_read  = valid_q & ctrl_q.mem_read;
    assign out_mem_write = valid_q & ctrl_q.mem_write;

`ifdef ID_EX_HAZARD_STATS_EN
    // ------------------------------------------------------------------
    // Hazard statistics
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q,   fwd_cnt_d;
    logic        fwd_used;
    logic        unused_op_a_hi;

    assign fwd_used       = is_bypass(sel_a) || is_bypass(sel_b);
    assign unused_op_a_hi = ^op_a_full[DATA_WIDTH-1:DMEM_ADDRESS_WIDTH];

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if ((action == ACT_LOAD_USE) && (stall_cnt_q != COUNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((action == ACT_CAPTURE) && in_valid && fwd_used &&
            (fwd_cnt_q != COUNT_MAX)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign fwd_count   = fwd_cnt_q;
`else
    // Select codes only feed the statistics; the upper bits of the widened
    // operand A are never used.
    logic unused_fwd_bits;
    assign unused_fwd_bits = ^{op_a_full[DATA_WIDTH-1:DMEM_ADDRESS_WIDTH],
                               sel_a, sel_b};
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. A behavioural model of the stage (what the
// registered outputs and stall must be, derived from the forwarding, hazard,
// hold, flush and reset rules) is checked against the DUT on every falling
// edge; hand-computed literal expectations pin the model on the key scenarios.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ------------------------------------------------------------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_reg_write, in_mem_read, in_mem_write;
    logic [2:0]  in_r1addr, in_r2addr, in_waddr;
    logic [7:0]  in_r1data;
    logic [63:0] in_r2data;
    logic        exm_reg_write, mwb_reg_write;
    logic [2:0]  exm_waddr, mwb_waddr;
    logic [63:0] exm_data, mwb_data;
    logic        hold_i, flush_i;
    logic        stall_o, out_valid;
    logic [7:0]  out_addr;
    logic [63:0] out_sdata;
    logic [2:0]  out_waddr;
    logic        out_reg_write, out_mem_read, out_mem_write;
`ifdef ID_EX_HAZARD_STATS_EN
    logic [31:0] stall_count, fwd_count;
`endif

    always #5 clock = ~clock;

    id_ex_stage dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_r1addr     (in_r1addr),
        .in_r2addr     (in_r2addr),
        .in_r1data     (in_r1data),
        .in_r2data     (in_r2data),
        .in_waddr      (in_waddr),
        .in_reg_write  (in_reg_write),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .exm_reg_write (exm_reg_write),
        .exm_waddr     (exm_waddr),
        .exm_data      (exm_data),
        .mwb_reg_write (mwb_reg_write),
        .mwb_waddr     (mwb_waddr),
        .mwb_data      (mwb_data),
        .hold_i        (hold_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .out_valid     (out_valid),
        .out_addr      (out_addr),
        .out_sdata     (out_sdata),
        .out_waddr     (out_waddr),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write)
`ifdef ID_EX_HAZARD_STATS_EN
        ,
        .stall_count   (stall_count),
        .fwd_count     (fwd_count)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and check task
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic        m_valid = 1'b0;
    logic [7:0]  m_addr  = '0;
    logic [63:0] m_sdata = '0;
    logic [2:0]  m_waddr = '0;
    logic        m_rw = 1'b0, m_mr = 1'b0, m_mw = 1'b0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_fwd_cnt   = '0;

    // Value a source register must read as, given the current bypass buses.
    function automatic logic [63:0] pick(input logic [2:0] idx, input logic [63:0] rf);
        if (idx == 3'd0) return 64'd0;
        if (exm_reg_write && exm_waddr == idx) return exm_data;
        if (mwb_reg_write && mwb_waddr == idx) return mwb_data;
        return rf;
    endfunction

    function automatic logic bypassed(input logic [2:0] idx);
        return (idx != 3'd0) &&
               ((exm_reg_write && exm_waddr == idx) || (mwb_reg_write && mwb_waddr == idx));
    endfunction

    function automatic logic m_load_use();
        return in_valid && m_valid && m_mr && (m_waddr != 3'd0) &&
               (m_waddr == in_r1addr || m_waddr == in_r2addr);
    endfunction

    function automatic logic m_stall();
        if (reset) return 1'b0;
        if (flush_i) return 1'b0;
        if (hold_i) return 1'b1;
        return m_load_use();
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_valid <= 1'b0; m_addr <= '0; m_sdata <= '0; m_waddr <= '0;
            m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
            m_stall_cnt <= '0; m_fwd_cnt <= '0;
        end else if (flush_i) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
        end else if (hold_i) begin
            m_valid <= m_valid;
        end else if (m_load_use()) begin
            m_valid <= 1'b0;
            if (m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt <= m_stall_cnt + 32'd1;
        end else begin
            m_valid <= in_valid;
            m_addr  <= 8'(pick(in_r1addr, {56'd0, in_r1data}));
            m_sdata <= pick(in_r2addr, in_r2data);
            m_waddr <= in_waddr;
            m_rw <= in_reg_write; m_mr <= in_mem_read; m_mw <= in_mem_write;
            if (in_valid && (bypassed(in_r1addr) || bypassed(in_r2addr)) &&
                m_fwd_cnt != 32'hFFFF_FFFF)
                m_fwd_cnt <= m_fwd_cnt + 32'd1;
        end
    end

    // Every-cycle compare, away from the rising edge.
    always @(negedge clock) begin
        chk("cmp_stall", {63'd0, stall_o}, {63'd0, m_stall()});
        chk("cmp_valid", {63'd0, out_valid}, {63'd0, m_valid});
        chk("cmp_ctrl", {61'd0, out_reg_write, out_mem_read, out_mem_write},
            {61'd0, m_valid & m_rw, m_valid & m_mr, m_valid & m_mw});
        if (m_valid) begin
            chk("cmp_addr", {56'd0, out_addr}, {56'd0, m_addr});
            chk("cmp_sdata", out_sdata, m_sdata);
            chk("cmp_waddr", {61'd0, out_waddr}, {61'd0, m_waddr});
        end
`ifdef ID_EX_HAZARD_STATS_EN
        chk("cmp_stall_count", {32'd0, stall_count}, {32'd0, m_stall_cnt});
        chk("cmp_fwd_count", {32'd0, fwd_count}, {32'd0, m_fwd_cnt});
`endif
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_r1addr = '0; in_r2addr = '0; in_r1data = '0; in_r2data = '0;
        in_waddr = '0; in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        exm_reg_write = 1'b0; exm_waddr = '0; exm_data = '0;
        mwb_reg_write = 1'b0; mwb_waddr = '0; mwb_data = '0;
        hold_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic present(input logic v, input logic [2:0] r1, input logic [7:0] r1d,
                           input logic [2:0] r2, input logic [63:0] r2d, input logic [2:0] wa,
                           input logic rw, input logic mr, input logic mw);
        in_valid = v; in_r1addr = r1; in_r1data = r1d; in_r2addr = r2; in_r2data = r2d;
        in_waddr = wa; in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
    endtask

    task automatic set_exm(input logic we, input logic [2:0] wa, input logic [63:0] d);
        exm_reg_write = we; exm_waddr = wa; exm_data = d;
    endtask

    task automatic set_mwb(input logic we, input logic [2:0] wa, input logic [63:0] d);
        mwb_reg_write = we; mwb_waddr = wa; mwb_data = d;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        chk("reset_stall", {63'd0, stall_o}, 64'd0);
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_addr", {56'd0, out_addr}, 64'd0);
        chk("reset_sdata", out_sdata, 64'd0);
        chk("reset_ctrl", {61'd0, out_reg_write, out_mem_read, out_mem_write}, 64'd0);
        reset = 1'b0;

        // Plain capture, no bypass.
        present(1, 3'd2, 8'h10, 3'd3, 64'hAA, 3'd5, 1, 0, 0);
        #1 chk("plain_stall", {63'd0, stall_o}, 64'd0);
        step();
        chk("plain_addr", {56'd0, out_addr}, 64'h10);
        chk("plain_sdata", out_sdata, 64'hAA);
        chk("plain_valid", {63'd0, out_valid}, 64'd1);

        // EX/MEM beats MEM/WB on the same index.
        set_exm(1, 3'd3, 64'h5);
        set_mwb(1, 3'd3, 64'h7);
        step();
        chk("prio_sdata", out_sdata, 64'h5);
        chk("prio_addr_rf", {56'd0, out_addr}, 64'h10);
        present(1, 3'd3, 8'h10, 3'd2, 64'hAA, 3'd5, 1, 0, 0);
        step();
        chk("prio_addr", {56'd0, out_addr}, 64'h05);
        chk("prio_sdata_rf", out_sdata, 64'hAA);

        // Register 0 ignores a matching bypass.
        set_exm(1, 3'd0, 64'hFF);
        set_mwb(0, 3'd0, 64'h0);
        present(1, 3'd0, 8'h55, 3'd0, 64'h66, 3'd1, 1, 0, 0);
        step();
        chk("zero_addr", {56'd0, out_addr}, 64'h00);
        chk("zero_sdata", out_sdata, 64'h0);

        // MEM/WB only; operand A keeps the low address bits.
        set_exm(0, 3'd0, 64'h0);
        set_mwb(1, 3'd6, 64'h1234_5678_9ABC_DEF0);
        present(1, 3'd6, 8'h01, 3'd1, 64'h77, 3'd2, 0, 0, 1);
        step();
        chk("mwb_addr", {56'd0, out_addr}, 64'hF0);
        chk("mwb_sdata", out_sdata, 64'h77);
        chk("mwb_memw", {63'd0, out_mem_write}, 64'd1);

        // in_valid = 0 captures a bubble.
        idle();
        step();
        chk("bubble_valid", {63'd0, out_valid}, 64'd0);

        // Load-use: load r4, then a consumer of r4.
        present(1, 3'd1, 8'h21, 3'd2, 64'h0, 3'd4, 1, 1, 0);
        step();
        chk("lu_load_mr", {63'd0, out_mem_read}, 64'd1);
        present(1, 3'd1, 8'h22, 3'd4, 64'h0, 3'd5, 1, 0, 0);
        #1 chk("lu_stall", {63'd0, stall_o}, 64'd1);
        step();
        chk("lu_bubble", {63'd0, out_valid}, 64'd0);
        chk("lu_addr_kept", {56'd0, out_addr}, 64'h21);
        chk("lu_mr_gated", {63'd0, out_mem_read}, 64'd0);
        chk("lu_stall_once", {63'd0, stall_o}, 64'd0);
        set_mwb(1, 3'd4, 64'h33);
        step();
        chk("lu_retry_sdata", out_sdata, 64'h33);
        chk("lu_retry_addr", {56'd0, out_addr}, 64'h22);
        chk("lu_retry_valid", {63'd0, out_valid}, 64'd1);

        // Flush suppresses a load-use stall.
        set_mwb(0, 3'd0, 64'h0);
        present(1, 3'd1, 8'h31, 3'd2, 64'h0, 3'd4, 1, 1, 0);
        step();
        present(1, 3'd4, 8'h32, 3'd2, 64'h0, 3'd5, 1, 0, 0);
        flush_i = 1'b1;
        #1 chk("flush_stall", {63'd0, stall_o}, 64'd0);
        step();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ctrl", {61'd0, out_reg_write, out_mem_read, out_mem_write}, 64'd0);
        flush_i = 1'b0;

        // Hold for 3 cycles with a load-use waiting behind it.
        present(1, 3'd1, 8'h42, 3'd2, 64'h99, 3'd4, 1, 1, 0);
        step();
        chk("hold_pre_addr", {56'd0, out_addr}, 64'h42);
        present(1, 3'd4, 8'h50, 3'd2, 64'h11, 3'd5, 1, 0, 0);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_stall", {63'd0, stall_o}, 64'd1);
            step();
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_addr", {56'd0, out_addr}, 64'h42);
            chk("hold_sdata", out_sdata, 64'h99);
            chk("hold_mr", {63'd0, out_mem_read}, 64'd1);
        end
        hold_i = 1'b0;
        #1 chk("hold_deferred_stall", {63'd0, stall_o}, 64'd1);
        step();
        chk("hold_deferred_bubble", {63'd0, out_valid}, 64'd0);
        step();
        chk("hold_retry_addr", {56'd0, out_addr}, 64'h50);
        chk("hold_retry_sdata", out_sdata, 64'h11);

        // Reset in the middle of a load-use stall.
        present(1, 3'd1, 8'h61, 3'd2, 64'h0, 3'd3, 1, 1, 0);
        step();
        present(1, 3'd1, 8'h62, 3'd3, 64'h0, 3'd5, 1, 0, 0);
        #1 chk("rst_mid_stall_pre", {63'd0, stall_o}, 64'd1);
        reset = 1'b1;
        #1 chk("rst_mid_stall", {63'd0, stall_o}, 64'd0);
        step();
        chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_addr", {56'd0, out_addr}, 64'd0);
        chk("rst_mid_sdata", out_sdata, 64'd0);
        chk("rst_mid_waddr", {61'd0, out_waddr}, 64'd0);
`ifdef ID_EX_HAZARD_STATS_EN
        chk("rst_mid_stall_count", {32'd0, stall_count}, 64'd0);
        chk("rst_mid_fwd_count", {32'd0, fwd_count}, 64'd0);
`endif
        reset = 1'b0;
        idle();
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the lab CPU. Sits directly downstream of the register file and consumes its two read ports:
  - operand A: memory address, DMEM_ADDRESS_WIDTH bits.
  - operand B: store/ALU data, DATA_WIDTH bits.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, stalls IF/ID for one cycle and inserts a bubble.
- Honours downstream hold and flush.

Parameters:
- REGFILE_ADDRESS_WIDTH, 3, register index width; register 0 reads as zero.
- DMEM_ADDRESS_WIDTH, 8, width of operand A / data-memory address.
- DATA_WIDTH, 64, width of operand B and forwarded data.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decoded instruction present.
- in_r1addr, in_r2addr  in  REGFILE_ADDRESS_WIDTH  source indices (also driven to regfile).
- in_r1data  in  DMEM_ADDRESS_WIDTH  regfile port 1 data.
- in_r2data  in  DATA_WIDTH  regfile port 2 data.
- in_waddr  in  REGFILE_ADDRESS_WIDTH  destination index.
- in_reg_write, in_mem_read, in_mem_write  in  1  decoded controls.
- exm_reg_write  in  1  EX/MEM writeback pending.
- exm_waddr  in  REGFILE_ADDRESS_WIDTH  EX/MEM destination.
- exm_data  in  DATA_WIDTH  EX/MEM result.
- mwb_reg_write  in  1  MEM/WB writeback pending.
- mwb_waddr  in  REGFILE_ADDRESS_WIDTH  MEM/WB destination.
- mwb_data  in  DATA_WIDTH  MEM/WB result.
- hold_i  in  1  downstream stall; freeze stage.
- flush_i  in  1  kill the instruction entering this stage.
- stall_o  out  1  to IF/ID: do not advance.
- out_valid  out  1  registered valid.
- out_addr  out  DMEM_ADDRESS_WIDTH  registered operand A.
- out_sdata  out  DATA_WIDTH  registered operand B.
- out_waddr  out  REGFILE_ADDRESS_WIDTH  registered destination.
- out_reg_write, out_mem_read, out_mem_write  out  1  registered controls, gated by out_valid.

Behaviour:
- Reset:
  - All out_* registers go to 0.
  - stall_o = 0.
  - Optional counters clear.
- Latency: 1 cycle from inputs to out_*.
- Operand selection, per source and in priority order:
  1. Index 0 → 0.
  2. exm_reg_write and exm_waddr == index → exm_data.
  3. mwb_reg_write and mwb_waddr == index → mwb_data.
  4. Otherwise → regfile data.
- Operand A takes the low DMEM_ADDRESS_WIDTH bits of any forwarded value.
- Load-use hazard (load_use): all of the following hold:
  - in_valid.
  - out_valid and out_mem_read.
  - out_waddr != 0.
  - out_waddr equals in_r1addr or in_r2addr.
- On load_use:
  - stall_o = 1 combinationally.
  - Next cycle out_valid = 0 (bubble); the other out_* keep their values but are gated.
  - The instruction stays in IF/ID and is re-presented next cycle. It then forwards from MEM/WB; no second stall.
- hold_i = 1:
  - All out_* registers keep their value.
  - stall_o = 1.
  - The load_use bubble is deferred while hold_i = 1.
- flush_i = 1 (and hold_i = 0): next out_valid = 0 and all out control bits = 0; the load_use stall is suppressed.
- Priority: reset > flush_i > hold_i > load_use > normal capture.
- in_valid = 0 with no other event: a bubble is captured (out_valid = 0).
- Reset asserted mid-stall: stall_o drops in the same cycle; the bubble is discarded.

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- Defined:
  - Adds outputs stall_count (32) and fwd_count (32), both saturating.
  - stall_count increments each cycle load_use causes a bubble.
  - fwd_count increments each captured valid instruction where either operand used EX/MEM or MEM/WB data.
  - Both clear on reset.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package:
  - REGFILE_ADDRESS_WIDTH, DMEM_ADDRESS_WIDTH, DATA_WIDTH.
  - Forward-select encoding FWD_NONE / FWD_EXM / FWD_MWB / FWD_ZERO.
  - The control-bundle field order (reg_write, mem_read, mem_write).
- One sub-module, fwd_mux: purely combinational. Takes one source index plus both bypass buses and the regfile data; returns the selected operand and its select code. Instantiated twice; the stage logic lives in id_ex_stage.

Test Plan:
- Plain capture: r1addr = 2 with in_r1data = 8'h10; r2addr = 3 with in_r2data = 64'hAA; no bypass → next cycle out_addr = 8'h10, out_sdata = 64'hAA, out_valid = 1.
- Forward priority: exm (waddr 3, data 64'h5) and mwb (waddr 3, data 64'h7) both active, r2addr = 3 → out_sdata = 64'h5. With r1addr = 3 instead → out_addr = 8'h05.
- Register-zero guard: r1addr = 0, exm_waddr = 0 with data 64'hFF → out_addr = 8'h00.
- Load-use: load to r4 held in stage, next instruction reads r4 → stall_o = 1 for exactly 1 cycle, then out_valid = 0. On the retry, with mwb (waddr 4, data 64'h33) → out_sdata = 64'h33, stall_o = 0.
- Flush and hold interplay:
  - flush_i = 1 together with a load_use condition → stall_o = 0 and next out_valid = 0.
  - hold_i = 1 for 3 cycles → out_* unchanged and stall_o = 1 throughout.
- Reset mid-stall: assert reset during a load_use stall → stall_o = 0 the same cycle and all out_* = 0 next edge. With ID_EX_HAZARD_STATS_EN defined, stall_count = 0 after reset.
